vga_pong_renderer: RTL and testbench
====================================

// Module: vga_pong_renderer
// PURPOSE
//  Display end of the pong_game interface: 640x480@60 VGA timing generator plus object renderer.
//  Drives frame_start (one pulse per frame, at start of vertical blanking) into pong_game.
//  Consumes pong_game's ball/paddle positions, shadows them once per frame and paints the pixels.
//  Sits between pong_game and the pico2-ice VGA pins; runs on the ~25.2 MHz pixel clock.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing, pixels (H_TOTAL = 800)
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing, lines (V_TOTAL = 525)
//  BALL_SIZE 8   : ball square edge, pixels
//  PADDLE_W 8    : paddle width, pixels
//  PADDLE_H 64   : paddle height, pixels (paddle centre = paddle_y + PADDLE_H/2)
//  COLOR_W 4     : bits per colour channel
// PORTS
//  clk          in   1        pixel clock
//  reset_n      in   1        asynchronous active-low reset
//  ball_x       in   10       ball top-left x, from pong_game
//  ball_y       in   10       ball top-left y
//  paddle_x     in   10       paddle top-left x
//  paddle_y     in   10       paddle top-left y
//  frame_start  out  1        1-cycle pulse per frame, to pong_game
//  hsync        out  1        horizontal sync, active low
//  vsync        out  1        vertical sync, active low
//  active       out  1        1 while the output pixel is in the visible area
//  pixel_x      out  10       x of the output pixel (valid when active=1)
//  pixel_y      out  10       y of the output pixel (valid when active=1)
//  red/green/blue out COLOR_W  pixel colour
// BEHAVIOUR
//  - Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. v_cnt increments when h_cnt wraps. Both wrap to 0 after frame end.
//  - Every output is registered. Each output reflects the (h_cnt,v_cnt) of the previous cycle, so latency is 1 clk and all outputs stay mutually aligned.
//  - active  = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
//  - hsync=0 when h_cnt in [656,751]. vsync=0 when v_cnt in [490,491].
//  - frame_start=1 for exactly one cycle, when h_cnt==0 && v_cnt==V_ACTIVE (first blanking line).
//    Period is exactly 420000 clk.
//  - Shadow registers: all four positions are captured only when h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
//    Input changes during a frame never tear the image.
//  - Hit test uses 11-bit unsigned compares; no wrap-around.
//    ball_hit   = bx<=x<bx+BALL_SIZE && by<=y<by+BALL_SIZE.
//    paddle_hit = same test with PADDLE_W x PADDLE_H.
//    Objects extending past x=639 or y=479 are clipped and never reappear on the next line or frame.
//  - Colour: ball_hit -> all channels max (white). Else paddle_hit -> green max, red/blue 0.
//    Else black. Ball has priority on overlap. Colour is always 0 when not active.
//  - Reset (async assert, sync-safe release):
//    h_cnt=v_cnt=0; shadows=0; frame_start=0; hsync=vsync=1; active=0; pixel_x=pixel_y=0; rgb=0.
//    Reset mid-frame restarts timing at (0,0). The first frame_start comes 480 lines after release.
//    Shadows stay 0 until the first frame boundary.
// TESTING
//  1 Free-run 2 frames -> hsync period 800 clk, low 96 clk; vsync low 1600 clk starting on line 490.
//    frame_start spacing 420000 clk, width 1.
//  2 Release reset mid-stream -> outputs at reset values during reset; first frame_start 384000+1 clk after release.
//  3 ball=(320,240), paddle=(0,240), 1 frame to load -> frame 2: white at x 320..327, y 240..247.
//    Black at x=319 and x=328 on line 240. Green at x 0..7, y 240..303. Black at (8,240) and (0,304).
//  4 Change ball_x to 100 during line 200 of frame 2 -> frame 2 still shows ball at 320. Frame 3 shows it at 100.
//  5 ball=(636,476) -> white only at x 636..639 on lines 476..479. Line 477 x 0..3 black. Line 0 of the next frame black.
//  6 ball=(4,250) overlapping paddle -> white wins at (4..7,250). Blanking-interval rgb is 0 throughout.

Source files
------------

// File: rtl/vga_pong_renderer.sv
// VGA timing generator and ball/paddle renderer for the pong display path.
// Timing is parameterised; defaults give 640x480@60 on a ~25.2 MHz pixel clock.
module vga_pong_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 8,
    parameter int PADDLE_H  = 64,
    parameter int COLOR_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic [9:0]         paddle_x,
    input  logic [9:0]         paddle_y,
    output logic               frame_start,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [9:0]         pixel_x,
    output logic [9:0]         pixel_y,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [COLOR_W-1:0] C_MAX = '1;

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] sh_bx, sh_by, sh_px, sh_py;
    logic       h_wrap, frame_end;

    assign h_wrap    = (h_cnt == H_LAST);
    assign frame_end = h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Positions are latched only on the last pixel of a frame so a whole frame
    // is always drawn from one consistent set of coordinates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_bx <= '0;
            sh_by <= '0;
            sh_px <= '0;
            sh_py <= '0;
        end else if (frame_end) begin
            sh_bx <= ball_x;
            sh_by <= ball_y;
            sh_px <= paddle_x;
            sh_py <= paddle_y;
        end
    end

    logic [10:0]        x11, y11;
    logic               vis, ball_hit, paddle_hit;
    logic [COLOR_W-1:0] r_nxt, g_nxt, b_nxt;

    // 11-bit compares keep bx+size from wrapping, so clipped objects stay clipped.
    always_comb begin
        x11 = {1'b0, h_cnt};
        y11 = {1'b0, v_cnt};
        vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        ball_hit = (x11 >= {1'b0, sh_bx}) && (x11 < {1'b0, sh_bx} + 11'(BALL_SIZE)) &&
                   (y11 >= {1'b0, sh_by}) && (y11 < {1'b0, sh_by} + 11'(BALL_SIZE));
        paddle_hit = (x11 >= {1'b0, sh_px}) && (x11 < {1'b0, sh_px} + 11'(PADDLE_W)) &&
                     (y11 >= {1'b0, sh_py}) && (y11 < {1'b0, sh_py} + 11'(PADDLE_H));
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (vis && ball_hit) begin
            r_nxt = C_MAX;
            g_nxt = C_MAX;
            b_nxt = C_MAX;
        end else if (vis && paddle_hit) begin
            g_nxt = C_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            frame_start <= (h_cnt == 10'd0) && (v_cnt == V_VIS);
            hsync       <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
            vsync       <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
            active      <= vis;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            red         <= r_nxt;
            green       <= g_nxt;
            blue        <= b_nxt;
        end
    end

endmodule

// File: tb/tb_vga_pong_renderer.sv
// Bench for vga_pong_renderer on a shrunken screen geometry; every output is
// compared each cycle against a frame-position model derived from elapsed cycles.
module tb_vga_pong_renderer;

    localparam int HA = 32, HF = 2, HS = 4, HB = 2;
    localparam int VA = 80, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BS = 8, PW = 8, PH = 64;

    logic       clk;
    logic       reset_n;
    logic [9:0] ball_x, ball_y, paddle_x, paddle_y;
    logic       frame_start, hsync, vsync, active;
    logic [9:0] pixel_x, pixel_y;
    logic [3:0] red, green, blue;

    vga_pong_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH), .COLOR_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .active(active),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .red(red), .green(green), .blue(blue)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k = 0;          // rising edges since reset release
    int last_fs = -1;
    int sbx = 0, sby = 0, spx = 0, spy = 0;
    logic [35:0] exp_q[$];

    // Expected output bundle for frame position p drawn with the given object set.
    function automatic logic [35:0] model(int p, int bx, int by, int px, int py);
        int x = p % HT;
        int y = p / HT;
        bit act = (x < HA) && (y < VA);
        bit hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        bit vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        bit fs  = (x == 0) && (y == VA);
        bit bh  = act && x >= bx && x < bx + BS && y >= by && y < by + BS;
        bit ph  = act && x >= px && x < px + PW && y >= py && y < py + PH;
        logic [3:0] r = bh ? 4'hF : 4'h0;
        logic [3:0] g = (bh || ph) ? 4'hF : 4'h0;
        logic [3:0] b = bh ? 4'hF : 4'h0;
        return {fs, hs, vs, act, 10'(x), 10'(y), r, g, b};
    endfunction

    function automatic logic [35:0] observed();
        return {frame_start, hsync, vsync, active, pixel_x, pixel_y, red, green, blue};
    endfunction

    task automatic check_reset(input string tag);
        logic [35:0] obs = observed();
        logic [35:0] rst_v = {1'b0, 1'b1, 1'b1, 1'b0, 20'd0, 12'd0};
        checks++;
        assert (obs === rst_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, rst_v);
        end
    endtask

    // driver + scoreboard: one pixel clock, then compare at the falling edge
    task automatic tick();
        int p;
        logic [35:0] obs, exp_v;
        @(posedge clk);
        p = k % FRAME;
        exp_q.push_back(model(p, sbx, sby, spx, spy));
        if (p == FRAME - 1) begin
            sbx = int'(ball_x);
            sby = int'(ball_y);
            spx = int'(paddle_x);
            spy = int'(paddle_y);
        end
        k++;
        @(negedge clk);
        obs = observed();
        exp_v = exp_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL pixel k=%0d observed=%h expected=%h", k, obs, exp_v);
        end
        if (frame_start === 1'b1) begin
            checks++;
            if (last_fs >= 0) begin
                assert (k - last_fs === FRAME) else begin
                    errors++;
                    $error("FAIL fs_period observed=%0d expected=%0d", k - last_fs, FRAME);
                end
            end else begin
                assert (k === VA * HT + 1) else begin
                    errors++;
                    $error("FAIL fs_first observed=%0d expected=%0d", k, VA * HT + 1);
                end
            end
            last_fs = k;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_objs(input int bx, input int by, input int px, input int py);
        ball_x   = 10'(bx);
        ball_y   = 10'(by);
        paddle_x = 10'(px);
        paddle_y = 10'(py);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        last_fs = -1;
        sbx = 0; sby = 0; spx = 0; spy = 0;
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        set_objs(16, 40, 0, 40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        release_reset();

        // frame 0 draws the zero shadows, frame 1 the loaded objects;
        // a mid-frame ball_x change shows up only from frame 2
        run(FRAME + 20 * HT);
        ball_x = 10'd5;
        run(2 * FRAME - 20 * HT);

        // bottom-right clipping
        set_objs(HA - 4, VA - 4, 20, 0);
        run(2 * FRAME);

        // ball overlapping paddle: ball wins
        set_objs(4, 50, 0, 46);
        run(2 * FRAME);

        // random object positions, updated at random points in each frame
        for (int seg = 0; seg < 6; seg++) begin
            int bx = $urandom_range(0, HA + 8);
            int by = $urandom_range(0, VA + 8);
            int px = $urandom_range(0, HA + 8);
            int py = $urandom_range(0, VA + 8);
            if ($urandom_range(0, 5) == 0) bx = 1023;
            if ($urandom_range(0, 5) == 0) py = 1023;
            set_objs(bx, by, px, py);
            run($urandom_range(FRAME / 4, FRAME / 2));
        end

        // asynchronous reset in the middle of a line
        run(1234);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("reset_mid");
        end
        set_objs($urandom_range(0, HA), $urandom_range(0, VA), 10, 10);
        release_reset();
        run(VA * HT + 3 * HT);

        checks++;
        assert (last_fs === VA * HT + 1) else begin
            errors++;
            $error("FAIL fs_after_reset observed=%0d expected=%0d", last_fs, VA * HT + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
